// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit
//  Desc     : Program counter and instruction fetch sequencer. A three-state
//             FSM (IDLE -> FETCH -> EXEC -> FETCH ...) requests an instruction
//             at PC, latches it on ack, holds it for decode until retire, then
//             advances PC sequentially or to a word-aligned branch target.
//  Config   : MISALIGN_TRAP_EN - when defined, a taken branch to a target
//             with target[1] set redirects to TRAP_VECTOR and pulses
//             misalign_trap for one cycle. When undefined, target[1:0] is
//             simply cleared and misalign_trap is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_src,
    input  logic [31:0] target,
    input  logic        retire,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic        misalign_trap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] w_next_pc;

    // Sequential successor wraps naturally in 32-bit arithmetic.
    assign PC_plus4  = PC + 32'd4;
    assign imem_addr = PC;

    // Next PC chosen at retire; branch targets are forced word-aligned.
    assign w_next_pc = PC_src ? {target[31:2], 2'b00} : PC_plus4;

`ifdef MISALIGN_TRAP_EN
    // target[0] plays no role even with trapping enabled.
    logic w_unused;
    assign w_unused = target[0];

    // Fetch sequencer with misaligned-target trap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            PC            <= {RESET_VECTOR[31:2], 2'b00};
            instr         <= 32'd0;
            instr_valid   <= 1'b0;
            imem_req      <= 1'b0;
            misalign_trap <= 1'b0;
        end else begin
            misalign_trap <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state  <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        r_state     <= EXEC;
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                    end
                end
                EXEC: begin
                    if (retire) begin
                        r_state     <= FETCH;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        if (PC_src && target[1]) begin
                            PC            <= {TRAP_VECTOR[31:2], 2'b00};
                            misalign_trap <= 1'b1;
                        end else begin
                            PC <= w_next_pc;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                end
            endcase
        end
    end
`else
    // Low target bits and the trap vector have no function in this build.
    logic w_unused;
    assign w_unused      = ^{target[1:0], TRAP_VECTOR};
    assign misalign_trap = 1'b0;

    // Fetch sequencer without trapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            PC          <= {RESET_VECTOR[31:2], 2'b00};
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state  <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        r_state     <= EXEC;
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                    end
                end
                EXEC: begin
                    if (retire) begin
                        r_state     <= FETCH;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        PC          <= w_next_pc;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_unit
//  Desc     : Directed self-checking bench for pc_fetch_unit. Expected values
//             follow MISALIGN_TRAP_EN when it is defined for the build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        PC_src;
    logic [31:0] target;
    logic        retire;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        misalign_trap;

    int n_checks = 0;
    int n_pass   = 0;

    pc_fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PC_src        (PC_src),
        .target        (target),
        .retire        (retire),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .PC            (PC),
        .PC_plus4      (PC_plus4),
        .misalign_trap (misalign_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ack in the current FETCH cycle with the given word.
    task automatic fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
    endtask

    // Retire the current EXEC instruction with the given branch decision.
    task automatic do_retire(input logic src, input logic [31:0] tgt);
        retire = 1'b1;
        PC_src = src;
        target = tgt;
        step();
        retire = 1'b0;
        PC_src = 1'b0;
        target = 32'd0;
    endtask

    initial begin
        rst        = 1'b0;
        PC_src     = 1'b0;
        target     = 32'd0;
        retire     = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        #2 rst = 1'b1;
        #1;
        chk("rst_req",   {31'd0, imem_req},      32'd0);
        chk("rst_pc",    PC,                     32'h0000_0000);
        chk("rst_instr", instr,                  32'd0);
        chk("rst_valid", {31'd0, instr_valid},   32'd0);
        chk("rst_trap",  {31'd0, misalign_trap}, 32'd0);
        step();
        step();

        // Reset release: one IDLE cycle, then fetch of the reset vector.
        rst = 1'b0;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("fetch0_req",  {31'd0, imem_req}, 32'd1);
        chk("fetch0_addr", imem_addr,         32'h0000_0000);
        chk("fetch0_p4",   PC_plus4,          32'h0000_0004);

        // Not-taken instruction.
        fetch(32'h0000_0013);
        chk("nt_instr", instr,                32'h0000_0013);
        chk("nt_valid", {31'd0, instr_valid}, 32'd1);
        chk("nt_req",   {31'd0, imem_req},    32'd0);
        // Ack outside FETCH is ignored.
        fetch(32'hDEAD_BEEF);
        chk("exec_ack_instr", instr,                32'h0000_0013);
        chk("exec_ack_valid", {31'd0, instr_valid}, 32'd1);
        do_retire(1'b0, 32'h0000_0040);
        chk("nt_pc",    PC,                   32'h0000_0004);
        chk("nt_addr",  imem_addr,            32'h0000_0004);
        chk("nt_rvld",  {31'd0, instr_valid}, 32'd0);
        chk("nt_rreq",  {31'd0, imem_req},    32'd1);
        chk("nt_p4",    PC_plus4,             32'h0000_0008);

        // Retire during FETCH is ignored.
        do_retire(1'b1, 32'h0000_0080);
        chk("fetch_ret_pc",  PC,                32'h0000_0004);
        chk("fetch_ret_req", {31'd0, imem_req}, 32'd1);

        // Taken branch.
        fetch(32'h0000_0063);
        do_retire(1'b1, 32'h0000_0040);
        chk("tk_pc",   PC,                32'h0000_0040);
        chk("tk_addr", imem_addr,         32'h0000_0040);
        chk("tk_req",  {31'd0, imem_req}, 32'd1);

        // Misaligned taken target.
        fetch(32'h0000_0063);
        do_retire(1'b1, 32'h0000_0042);
`ifdef MISALIGN_TRAP_EN
        chk("mis_pc",   PC,                     32'h0000_0100);
        chk("mis_trap", {31'd0, misalign_trap}, 32'd1);
`else
        chk("mis_pc",   PC,                     32'h0000_0040);
        chk("mis_trap", {31'd0, misalign_trap}, 32'd0);
`endif
        step();
        chk("mis_trap_end", {31'd0, misalign_trap}, 32'd0);

        // Wrap-around at top of address space.
        fetch(32'h0000_0063);
        do_retire(1'b1, 32'hFFFF_FFFC);
        chk("top_pc", PC,       32'hFFFF_FFFC);
        chk("top_p4", PC_plus4, 32'h0000_0000);
        fetch(32'h0000_0013);
        do_retire(1'b0, 32'h0000_0123);
        chk("wrap_pc", PC, 32'h0000_0000);

        // Move off the reset vector so the restart is observable.
        fetch(32'h0000_0063);
        do_retire(1'b1, 32'h0000_0020);
        chk("pre_rst_pc",  PC,                32'h0000_0020);
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);

        // Reset mid-fetch, asserted between clock edges.
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_pc",  PC,                32'h0000_0000);
        step();
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0BAD;
        step();
        chk("rst_ack_instr", instr,                32'd0);
        chk("rst_ack_valid", {31'd0, instr_valid}, 32'd0);
        // Release with ack still high: the IDLE cycle must ignore it.
        rst = 1'b0;
        chk("rel_idle_req", {31'd0, imem_req}, 32'd0);
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        chk("rel_req",   {31'd0, imem_req},    32'd1);
        chk("rel_addr",  imem_addr,            32'h0000_0000);
        chk("rel_valid", {31'd0, instr_valid}, 32'd0);
        chk("rel_instr", instr,                32'd0);

        // Normal fetch after restart.
        fetch(32'h0000_0093);
        chk("post_instr", instr,                32'h0000_0093);
        chk("post_valid", {31'd0, instr_valid}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
